cronometro_param: RTL and testbench

- Parametrised successor to the fixed 24 h stopwatch counter: centiseconds, seconds, minutes and hours, with run/stop toggling on a button edge.
- Adds:
  - a configurable sub-second modulus and hour modulus;
  - synchronous preset load;
  - a countdown-timer mode that stops at zero and raises done;
  - a lap-freeze display;
  - an overflow pulse.
- Sits between the 100 Hz clock divider and the 7-segment display driver.

---
 rtl/cronometro_param_if.sv | 39 +++
 rtl/cronometro_param.sv | 215 +++++++++++++++++++++
 tb/tb_cronometro_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cronometro_param_if.sv
// Stopwatch control/display bundle: button and preset inputs toward the
// counter, displayed time and status flags back out.
interface cronometro_param_if #(
  parameter int CS_W = 7,
  parameter int HR_W = 5
);
  logic            start_stop;
  logic            clear;
  logic            direction;
  logic            load;
  logic [CS_W-1:0] load_cs;
  logic [5:0]      load_sec;
  logic [5:0]      load_min;
  logic [HR_W-1:0] load_hr;
  logic            lap;

  logic [CS_W-1:0] centisec;
  logic [5:0]      sec;
  logic [5:0]      min;
  logic [HR_W-1:0] hr;
  logic            running;
  logic            lap_active;
  logic            done;
  logic            overflow;

  modport master (
    output start_stop, clear, direction, load,
    output load_cs, load_sec, load_min, load_hr, lap,
    input  centisec, sec, min, hr,
    input  running, lap_active, done, overflow
  );

  modport slave (
    input  start_stop, clear, direction, load,
    input  load_cs, load_sec, load_min, load_hr, lap,
    output centisec, sec, min, hr,
    output running, lap_active, done, overflow
  );
endinterface

// File: rtl/cronometro_param.sv
// Parametrised up/down stopwatch / countdown timer clocked by the 100 Hz tick.
// Live count cascades centisec -> sec -> min -> hr; a lap snapshot can freeze
// the display while the live count keeps advancing.
module cronometro_param #(
  parameter int CS_MOD    = 100,
  parameter int CS_W      = 7,
  parameter int HR_MOD    = 24,
  parameter int HR_W      = 5,
  parameter int WRAP_DOWN = 0
) (
  input  logic             clk_100Hz,
  input  logic             rst_n,
  cronometro_param_if.slave bus
);

  localparam logic [CS_W-1:0] CS_MAX = CS_W'(CS_MOD - 1);
  localparam logic [CS_W-1:0] CS_ONE = CS_W'(1);
  localparam logic [5:0]      SM_MAX = 6'd59;
  localparam logic [5:0]      SM_ONE = 6'd1;
  localparam logic [HR_W-1:0] HR_MAX = HR_W'(HR_MOD - 1);
  localparam logic [HR_W-1:0] HR_ONE = HR_W'(1);

  // Presets saturate at the field terminal value so stored counts stay in range
  function automatic logic [CS_W-1:0] clamp_cs(input logic [CS_W-1:0] v);
    return (v > CS_MAX) ? CS_MAX : v;
  endfunction

  function automatic logic [5:0] clamp_sm(input logic [5:0] v);
    return (v > SM_MAX) ? SM_MAX : v;
  endfunction

  function automatic logic [HR_W-1:0] clamp_hr(input logic [HR_W-1:0] v);
    return (v > HR_MAX) ? HR_MAX : v;
  endfunction

  logic            start_stop_p0, lap_p0;
  logic [CS_W-1:0] cs_q, snap_cs_q, cs_n, snap_cs_n;
  logic [5:0]      sec_q, snap_sec_q, sec_n, snap_sec_n;
  logic [5:0]      min_q, snap_min_q, min_n, snap_min_n;
  logic [HR_W-1:0] hr_q, snap_hr_q, hr_n, snap_hr_n;
  logic            running_q, lap_active_q, done_q, overflow_q;
  logic            running_n, lap_active_n, done_n, overflow_n;

  logic            ss_edge, lap_edge;
  logic            cs_top, sec_top, min_top, hr_top;
  logic            cs_bot, sec_bot, min_bot, hr_bot;
  logic            live_max, live_zero, hold_zero, dec_zero;
  logic [CS_W-1:0] cs_inc, cs_dec;
  logic [5:0]      sec_inc, sec_dec, min_inc, min_dec;
  logic [HR_W-1:0] hr_inc, hr_dec;

  assign ss_edge  = bus.start_stop & ~start_stop_p0;
  assign lap_edge = bus.lap & ~lap_p0;

  assign cs_top  = (cs_q  == CS_MAX);
  assign sec_top = (sec_q == SM_MAX);
  assign min_top = (min_q == SM_MAX);
  assign hr_top  = (hr_q  == HR_MAX);
  assign cs_bot  = (cs_q  == '0);
  assign sec_bot = (sec_q == '0);
  assign min_bot = (min_q == '0);
  assign hr_bot  = (hr_q  == '0);

  assign live_max  = cs_top & sec_top & min_top & hr_top;
  assign live_zero = cs_bot & sec_bot & min_bot & hr_bot;

  // Cascaded increment: each field advances only when all lower fields wrap
  assign cs_inc  = cs_top ? '0 : cs_q + CS_ONE;
  assign sec_inc = cs_top ? (sec_top ? '0 : sec_q + SM_ONE) : sec_q;
  assign min_inc = (cs_top & sec_top) ? (min_top ? '0 : min_q + SM_ONE) : min_q;
  assign hr_inc  = (cs_top & sec_top & min_top) ? (hr_top ? '0 : hr_q + HR_ONE) : hr_q;

  // Cascaded decrement: each field borrows only when all lower fields are zero
  assign cs_dec  = cs_bot ? CS_MAX : cs_q - CS_ONE;
  assign sec_dec = cs_bot ? (sec_bot ? SM_MAX : sec_q - SM_ONE) : sec_q;
  assign min_dec = (cs_bot & sec_bot) ? (min_bot ? SM_MAX : min_q - SM_ONE) : min_q;
  assign hr_dec  = (cs_bot & sec_bot & min_bot) ? (hr_bot ? HR_MAX : hr_q - HR_ONE) : hr_q;

  assign dec_zero = (cs_dec == '0) && (sec_dec == '0) && (min_dec == '0) && (hr_dec == '0);

  // A stopped countdown sitting at zero cannot be restarted (it would finish at once)
  assign hold_zero = ~running_q & bus.direction & (WRAP_DOWN == 0) & live_zero;

  // Next-state: clear beats load beats counting; lap is handled alongside load/count
  always_comb begin
    cs_n         = cs_q;
    sec_n        = sec_q;
    min_n        = min_q;
    hr_n         = hr_q;
    snap_cs_n    = snap_cs_q;
    snap_sec_n   = snap_sec_q;
    snap_min_n   = snap_min_q;
    snap_hr_n    = snap_hr_q;
    running_n    = running_q;
    lap_active_n = lap_active_q;
    done_n       = 1'b0;
    overflow_n   = 1'b0;

    if (bus.clear) begin
      cs_n         = '0;
      sec_n        = '0;
      min_n        = '0;
      hr_n         = '0;
      snap_cs_n    = '0;
      snap_sec_n   = '0;
      snap_min_n   = '0;
      snap_hr_n    = '0;
      running_n    = 1'b0;
      lap_active_n = 1'b0;
    end else begin
      if (lap_edge) begin
        if (!lap_active_q) begin
          snap_cs_n    = cs_q;
          snap_sec_n   = sec_q;
          snap_min_n   = min_q;
          snap_hr_n    = hr_q;
          lap_active_n = 1'b1;
        end else begin
          lap_active_n = 1'b0;
        end
      end

      if (bus.load) begin
        cs_n  = clamp_cs(bus.load_cs);
        sec_n = clamp_sm(bus.load_sec);
        min_n = clamp_sm(bus.load_min);
        hr_n  = clamp_hr(bus.load_hr);
        if (ss_edge) running_n = ~running_q;
      end else begin
        if (ss_edge && !hold_zero) running_n = ~running_q;
        if (running_q) begin
          if (!bus.direction) begin
            cs_n       = cs_inc;
            sec_n      = sec_inc;
            min_n      = min_inc;
            hr_n       = hr_inc;
            overflow_n = live_max;
          end else if (live_zero) begin
            if (WRAP_DOWN != 0) begin
              cs_n       = CS_MAX;
              sec_n      = SM_MAX;
              min_n      = SM_MAX;
              hr_n       = HR_MAX;
              overflow_n = 1'b1;
            end else begin
              running_n = 1'b0;
              done_n    = 1'b1;
            end
          end else begin
            cs_n  = cs_dec;
            sec_n = sec_dec;
            min_n = min_dec;
            hr_n  = hr_dec;
            if ((WRAP_DOWN == 0) && dec_zero) begin
              running_n = 1'b0;
              done_n    = 1'b1;
            end
          end
        end
      end
    end
  end

  // Button history for rising-edge detection, updated every tick
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      start_stop_p0 <= 1'b0;
      lap_p0        <= 1'b0;
    end else begin
      start_stop_p0 <= bus.start_stop;
      lap_p0        <= bus.lap;
    end
  end

  // Live count, lap snapshot and status flags
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      cs_q         <= '0;
      sec_q        <= '0;
      min_q        <= '0;
      hr_q         <= '0;
      snap_cs_q    <= '0;
      snap_sec_q   <= '0;
      snap_min_q   <= '0;
      snap_hr_q    <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cs_q         <= cs_n;
      sec_q        <= sec_n;
      min_q        <= min_n;
      hr_q         <= hr_n;
      snap_cs_q    <= snap_cs_n;
      snap_sec_q   <= snap_sec_n;
      snap_min_q   <= snap_min_n;
      snap_hr_q    <= snap_hr_n;
      running_q    <= running_n;
      lap_active_q <= lap_active_n;
      done_q       <= done_n;
      overflow_q   <= overflow_n;
    end
  end

  assign bus.centisec   = lap_active_q ? snap_cs_q  : cs_q;
  assign bus.sec        = lap_active_q ? snap_sec_q : sec_q;
  assign bus.min        = lap_active_q ? snap_min_q : min_q;
  assign bus.hr         = lap_active_q ? snap_hr_q  : hr_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cronometro_param.sv
// Directed bench for cronometro_param: a default 24 h / stop-at-zero instance
// and a 12 h / wrap-down instance share the tick clock.
module tb_cronometro_param;

  logic clk_100Hz = 1'b0;
  logic rst_n;

  always #5 clk_100Hz = ~clk_100Hz;

  cronometro_param_if #(.CS_W(7), .HR_W(5)) bus_a ();
  cronometro_param_if #(.CS_W(7), .HR_W(4)) bus_b ();

  cronometro_param dut_a (
    .clk_100Hz (clk_100Hz),
    .rst_n     (rst_n),
    .bus       (bus_a)
  );

  cronometro_param #(
    .CS_MOD(100), .CS_W(7), .HR_MOD(12), .HR_W(4), .WRAP_DOWN(1)
  ) dut_b (
    .clk_100Hz (clk_100Hz),
    .rst_n     (rst_n),
    .bus       (bus_b)
  );

  typedef struct {
    string       tag;
    bit          b_inst;
    logic [27:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Packed view: hr, min, sec, centisec, running, lap_active, done, overflow
  function automatic logic [27:0] pk(int h, int m, int s, int c,
                                     bit r, bit l, bit d, bit o);
    return {5'(h), 6'(m), 6'(s), 7'(c), r, l, d, o};
  endfunction

  function automatic logic [27:0] obs_a();
    return {bus_a.hr, bus_a.min, bus_a.sec, bus_a.centisec,
            bus_a.running, bus_a.lap_active, bus_a.done, bus_a.overflow};
  endfunction

  function automatic logic [27:0] obs_b();
    return {1'b0, bus_b.hr, bus_b.min, bus_b.sec, bus_b.centisec,
            bus_b.running, bus_b.lap_active, bus_b.done, bus_b.overflow};
  endfunction

  task automatic push_a(input string t, input logic [27:0] v);
    exp_t e;
    e.tag = t; e.b_inst = 1'b0; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push_b(input string t, input logic [27:0] v);
    exp_t e;
    e.tag = t; e.b_inst = 1'b1; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [27:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = e.b_inst ? obs_b() : obs_a();
      n_assert++;
      assert (o === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h (hr,min,sec,cs,run,lap,done,ovf)",
               e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_100Hz);
    #1;
    check();
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.start_stop = 0; bus_a.clear = 0; bus_a.direction = 0; bus_a.load = 0;
    bus_a.load_cs = 0; bus_a.load_sec = 0; bus_a.load_min = 0; bus_a.load_hr = 0;
    bus_a.lap = 0;
    bus_b.start_stop = 0; bus_b.clear = 0; bus_b.direction = 0; bus_b.load = 0;
    bus_b.load_cs = 0; bus_b.load_sec = 0; bus_b.load_min = 0; bus_b.load_hr = 0;
    bus_b.lap = 0;

    #12;
    push_a("reset_a", pk(0, 0, 0, 0, 0, 0, 0, 0));
    push_b("reset_b", pk(0, 0, 0, 0, 0, 0, 0, 0));
    check();
    rst_n = 1'b1;

    // Start edge then 149 up steps
    bus_a.start_stop = 1;
    push_a("t1_start", pk(0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    repeat (148) tick();
    push_a("t1_149", pk(0, 0, 1, 49, 1, 0, 0, 0));
    tick();
    bus_a.start_stop = 0;

    // Full up wrap from 23:59:59.98
    bus_a.clear = 1;
    push_a("t2_clear", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_a.clear = 0; bus_a.load = 1; bus_a.start_stop = 1;
    bus_a.load_hr = 23; bus_a.load_min = 59; bus_a.load_sec = 59; bus_a.load_cs = 98;
    push_a("t2_load", pk(23, 59, 59, 98, 1, 0, 0, 0));
    tick();
    bus_a.load = 0;
    push_a("t2_step1", pk(23, 59, 59, 99, 1, 0, 0, 0));
    tick();
    push_a("t2_wrap", pk(0, 0, 0, 0, 1, 0, 0, 1));
    tick();
    push_a("t2_after", pk(0, 0, 0, 1, 1, 0, 0, 0));
    tick();

    // Clamp, then countdown to zero
    bus_a.start_stop = 0; bus_a.clear = 1;
    push_a("t3_clear", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_a.clear = 0; bus_a.load = 1;
    bus_a.load_hr = 31; bus_a.load_min = 63; bus_a.load_sec = 63; bus_a.load_cs = 127;
    push_a("t3_clamp", pk(23, 59, 59, 99, 0, 0, 0, 0));
    tick();
    bus_a.load_hr = 0; bus_a.load_min = 0; bus_a.load_sec = 0; bus_a.load_cs = 2;
    bus_a.direction = 1;
    push_a("t3_load", pk(0, 0, 0, 2, 0, 0, 0, 0));
    tick();
    bus_a.load = 0; bus_a.start_stop = 1;
    push_a("t3_start", pk(0, 0, 0, 2, 1, 0, 0, 0));
    tick();
    push_a("t3_down1", pk(0, 0, 0, 1, 1, 0, 0, 0));
    tick();
    push_a("t3_done", pk(0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    push_a("t3_done_pulse", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_a.start_stop = 0;
    tick();
    bus_a.start_stop = 1;
    push_a("t3_ignored", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    push_a("t3_still0", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_a.start_stop = 0; bus_a.direction = 0;

    // Wrap-down instance: 12 h modulus
    bus_b.direction = 1; bus_b.start_stop = 1;
    push_b("t4_start", pk(0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    push_b("t4_wrap", pk(11, 59, 59, 99, 1, 0, 0, 1));
    tick();
    push_b("t4_next", pk(11, 59, 59, 98, 1, 0, 0, 0));
    tick();
    bus_b.clear = 1;
    push_b("t4_clear", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_b.clear = 0; bus_b.start_stop = 0;

    // Lap freeze at 0.30, release at live 0.80
    bus_a.clear = 1;
    tick();
    bus_a.clear = 0; bus_a.start_stop = 1;
    push_a("t5_start", pk(0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    repeat (30) tick();
    bus_a.lap = 1;
    push_a("t5_lap_on", pk(0, 0, 0, 30, 1, 1, 0, 0));
    tick();
    bus_a.lap = 0;
    repeat (47) tick();
    push_a("t5_frozen", pk(0, 0, 0, 30, 1, 1, 0, 0));
    tick();
    bus_a.lap = 1;
    push_a("t5_lap_off", pk(0, 0, 0, 80, 1, 0, 0, 0));
    tick();

    // Clear beats load and start edge
    bus_a.lap = 0; bus_a.start_stop = 0;
    push_a("t6_run", pk(0, 0, 0, 81, 1, 0, 0, 0));
    tick();
    bus_a.lap = 1;
    push_a("t6_lap", pk(0, 0, 0, 81, 1, 1, 0, 0));
    tick();
    bus_a.lap = 0; bus_a.clear = 1; bus_a.load = 1; bus_a.start_stop = 1;
    bus_a.load_hr = 5; bus_a.load_min = 5; bus_a.load_sec = 5; bus_a.load_cs = 5;
    push_a("t6_clear_wins", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    bus_a.clear = 0; bus_a.load = 0;
    push_a("t6_no_reedge", pk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();

    // Asynchronous reset in the middle of a run
    bus_a.start_stop = 0;
    tick();
    bus_a.start_stop = 1;
    push_a("t7_start", pk(0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    repeat (20) tick();
    push_a("t7_run", pk(0, 0, 0, 21, 1, 0, 0, 0));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push_a("t7_async_rst", pk(0, 0, 0, 0, 0, 0, 0, 0));
    check();
    #3;
    rst_n = 1'b1;
    bus_a.start_stop = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
